// File: rtl/cam_pkg.sv
// Shared types, default geometry and helpers for the parametrised CAM.
package cam_pkg;

    localparam int unsigned CAM_DATA_WIDTH = 32;
    localparam int unsigned CAM_ADDR_WIDTH = 5;
    localparam int unsigned CAM_POP_MAX    = 1024;

    typedef logic [CAM_DATA_WIDTH-1:0] cam_data_t;
    typedef logic [CAM_ADDR_WIDTH-1:0] cam_idx_t;
    typedef logic [CAM_ADDR_WIDTH:0]   cam_cnt_t;

    // Number of set bits; callers zero-extend their hit vector to CAM_POP_MAX.
    function automatic int unsigned popcount(input logic [CAM_POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(CAM_POP_MAX); i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cam_if.sv
// Request/response bundle between the lookup logic (master) and the CAM (slave).
interface cam_if
    import cam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH
);

    logic                  read_i;
    logic [ADDR_WIDTH-1:0] read_index_i;
    logic                  write_i;
    logic [ADDR_WIDTH-1:0] write_index_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  inval_i;
    logic [ADDR_WIDTH-1:0] inval_index_i;
    logic                  search_i;
    logic [DATA_WIDTH-1:0] search_data_i;
    logic [DATA_WIDTH-1:0] search_mask_i;

    logic                  read_valid_o;
    logic [DATA_WIDTH-1:0] read_value_o;
    logic                  search_valid_o;
    logic [ADDR_WIDTH-1:0] search_index_o;
    logic                  search_multi_o;
    logic [ADDR_WIDTH:0]   search_count_o;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  full_o;
    logic                  empty_o;

    modport master (
        output read_i, read_index_i, write_i, write_index_i, write_data_i,
               inval_i, inval_index_i, search_i, search_data_i, search_mask_i,
        input  read_valid_o, read_value_o, search_valid_o, search_index_o,
               search_multi_o, search_count_o, count_o, full_o, empty_o
    );

    modport slave (
        input  read_i, read_index_i, write_i, write_index_i, write_data_i,
               inval_i, inval_index_i, search_i, search_data_i, search_mask_i,
        output read_valid_o, read_value_o, search_valid_o, search_index_o,
               search_multi_o, search_count_o, count_o, full_o, empty_o
    );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with any/multiple-hit flags (combinational).
module cam_prio_enc #(
    parameter int unsigned DEPTH = 32
) (
    input  logic [DEPTH-1:0]         vec_i,
    output logic [$clog2(DEPTH)-1:0] lowest_c_o,
    output logic                     any_c_o,
    output logic                     multi_c_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Scan from the top so the lowest set index is the last one assigned.
    always_comb begin
        lowest_c_o = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                lowest_c_o = IDX_W'(i);
            end
        end
    end

    assign any_c_o   = |vec_i;
    assign multi_c_o = |(vec_i & (vec_i - DEPTH'(1)));

endmodule

// File: rtl/cam_param.sv
// Registered-output CAM with per-entry valid bits, masked search, hit counting
// and an occupancy counter. Reads and searches observe pre-write array state.
module cam_param
    import cam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    cam_if.slave bus
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic                  read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0] read_value_q, read_value_d;
    logic                  search_valid_q, search_valid_d;
    logic [ADDR_WIDTH-1:0] search_index_q, search_index_d;
    logic                  search_multi_q, search_multi_d;
    logic [CNT_W-1:0]      search_count_q, search_count_d;

    logic [DEPTH-1:0]      hit_c;
    logic [ADDR_WIDTH-1:0] lowest_c;
    logic                  any_c;
    logic                  multi_c;
    logic                  wr_new_c;
    logic                  inval_hit_c;

    // Masked compare of every valid entry against the key.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            hit_c[i] = valid_q[i] &&
                       (((data_q[i] ^ bus.search_data_i) & bus.search_mask_i) == '0);
        end
    end

    cam_prio_enc #(
        .DEPTH (DEPTH)
    ) u_prio_enc (
        .vec_i      (hit_c),
        .lowest_c_o (lowest_c),
        .any_c_o    (any_c),
        .multi_c_o  (multi_c)
    );

    // Occupancy delta from pre-update valid bits; a same-index write cancels the invalidate.
    always_comb begin
        wr_new_c    = bus.write_i && !valid_q[bus.write_index_i];
        inval_hit_c = bus.inval_i && valid_q[bus.inval_index_i] &&
                      !(bus.write_i && (bus.write_index_i == bus.inval_index_i));

        valid_d = valid_q;
        if (bus.inval_i) begin
            valid_d[bus.inval_index_i] = 1'b0;
        end
        if (bus.write_i) begin
            valid_d[bus.write_index_i] = 1'b1;
        end

        count_d = count_q;
        if (wr_new_c && !inval_hit_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_new_c && inval_hit_c) begin
            count_d = count_q - CNT_W'(1);
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin
        read_valid_d = bus.read_i && valid_q[bus.read_index_i];
        read_value_d = read_value_q;
        if (bus.read_i) begin
            read_value_d = valid_q[bus.read_index_i] ? data_q[bus.read_index_i] : '0;
        end

        search_valid_d = bus.search_i && any_c;
        search_multi_d = bus.search_i && multi_c;
        search_count_d = '0;
        search_index_d = search_index_q;
        if (bus.search_i) begin
            search_count_d = CNT_W'(popcount(CAM_POP_MAX'(hit_c)));
            search_index_d = lowest_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q        <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            read_valid_q   <= 1'b0;
            read_value_q   <= '0;
            search_valid_q <= 1'b0;
            search_index_q <= '0;
            search_multi_q <= 1'b0;
            search_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            read_valid_q   <= read_valid_d;
            read_value_q   <= read_value_d;
            search_valid_q <= search_valid_d;
            search_index_q <= search_index_d;
            search_multi_q <= search_multi_d;
            search_count_q <= search_count_d;
        end
    end

    // Data storage carries no reset; stale contents are masked by the valid bits.
    always_ff @(posedge clk_i) begin
        if (rst_i && bus.write_i) begin
            data_q[bus.write_index_i] <= bus.write_data_i;
        end
    end

    assign bus.read_valid_o   = read_valid_q;
    assign bus.read_value_o   = read_value_q;
    assign bus.search_valid_o = search_valid_q;
    assign bus.search_index_o = search_index_q;
    assign bus.search_multi_o = search_multi_q;
    assign bus.search_count_o = search_count_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;

endmodule

// File: tb/tb_cam_param.sv
// Self-checking bench for cam_param: vector table plus hand-built sequences,
// with expectations queued at drive time and compared one cycle later.
module tb_cam_param;
    import cam_pkg::*;

    typedef struct {
        logic        rst;
        logic        rd;
        logic [4:0]  ridx;
        logic        wr;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  iidx;
        logic        sr;
        logic [31:0] sdata;
        logic [31:0] smask;
    } stim_t;

    typedef struct {
        logic [1:0]  chk;
        logic        rv;
        logic [31:0] rval;
        logic        sv;
        logic [4:0]  sidx;
        logic        sm;
        logic [5:0]  sc;
        logic [5:0]  cnt;
        logic        full;
        logic        empty;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    cam_if bus ();

    cam_param dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t op(int rd, int ridx, int wr, int widx, logic [31:0] wdata,
                                 int iv, int iidx, int sr, logic [31:0] sdata,
                                 logic [31:0] smask);
        stim_t s;
        s.rst   = 1'b1;
        s.rd    = (rd != 0);
        s.ridx  = 5'(ridx);
        s.wr    = (wr != 0);
        s.widx  = 5'(widx);
        s.wdata = wdata;
        s.iv    = (iv != 0);
        s.iidx  = 5'(iidx);
        s.sr    = (sr != 0);
        s.sdata = sdata;
        s.smask = smask;
        return s;
    endfunction

    function automatic exp_t ex(int rv, logic [31:0] rval, int sv, int sidx, int sm,
                                int sc, int cnt);
        exp_t e;
        e.chk   = 2'b11;
        e.rv    = (rv != 0);
        e.rval  = rval;
        e.sv    = (sv != 0);
        e.sidx  = 5'(sidx);
        e.sm    = (sm != 0);
        e.sc    = 6'(sc);
        e.cnt   = 6'(cnt);
        e.full  = (cnt == 32);
        e.empty = (cnt == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got 0x%0h, required 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk(tag, "count_o", 32'(bus.count_o), 32'(e.cnt));
        chk(tag, "full_o",  32'(bus.full_o),  32'(e.full));
        chk(tag, "empty_o", 32'(bus.empty_o), 32'(e.empty));
        if (e.chk[0]) begin
            chk(tag, "read_valid_o", 32'(bus.read_valid_o), 32'(e.rv));
            chk(tag, "read_value_o", bus.read_value_o, e.rval);
        end
        if (e.chk[1]) begin
            chk(tag, "search_valid_o", 32'(bus.search_valid_o), 32'(e.sv));
            chk(tag, "search_index_o", 32'(bus.search_index_o), 32'(e.sidx));
            chk(tag, "search_multi_o", 32'(bus.search_multi_o), 32'(e.sm));
            chk(tag, "search_count_o", 32'(bus.search_count_o), 32'(e.sc));
        end
    endtask

    // Drive one cycle of requests, queue its expectation, compare after the edge.
    task automatic apply(input string tag, input stim_t s, input exp_t e);
        @(negedge clk);
        rst_n             = s.rst;
        bus.read_i        = s.rd;
        bus.read_index_i  = s.ridx;
        bus.write_i       = s.wr;
        bus.write_index_i = s.widx;
        bus.write_data_i  = s.wdata;
        bus.inval_i       = s.iv;
        bus.inval_index_i = s.iidx;
        bus.search_i      = s.sr;
        bus.search_data_i = s.sdata;
        bus.search_mask_i = s.smask;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s scoreboard: queue empty, required one entry", tag);
        end else begin
            check_out(tag, sb_q.pop_front());
        end
    endtask

    vec_t tbl[18];

    initial begin
        stim_t s;
        exp_t  e;
        int    cnt;
        cam_data_t full_mask;

        n_cmp     = 0;
        n_bad     = 0;
        full_mask = '1;
        rst_n     = 1'b0;
        bus.read_i = 1'b0;  bus.read_index_i = '0;
        bus.write_i = 1'b0; bus.write_index_i = '0; bus.write_data_i = '0;
        bus.inval_i = 1'b0; bus.inval_index_i = '0;
        bus.search_i = 1'b0; bus.search_data_i = '0; bus.search_mask_i = '0;

        tbl[0]  = '{op(1,3, 0,0,0,            0,0,  0,0,0),                ex(0,0,           0,0,0,0, 0)};
        tbl[1]  = '{op(0,0, 1,7,'hDEADBEEF,   0,0,  0,0,0),                ex(0,0,           0,0,0,0, 1)};
        tbl[2]  = '{op(1,7, 0,0,0,            0,0,  1,'hDEADBEEF,full_mask), ex(1,'hDEADBEEF,  1,7,0,1, 1)};
        tbl[3]  = '{op(0,0, 1,9,'h55,         0,0,  0,0,0),                ex(0,'hDEADBEEF,  0,7,0,0, 2)};
        tbl[4]  = '{op(0,0, 1,4,'h55,         0,0,  0,0,0),                ex(0,'hDEADBEEF,  0,7,0,0, 3)};
        tbl[5]  = '{op(0,0, 1,20,'h55,        0,0,  0,0,0),                ex(0,'hDEADBEEF,  0,7,0,0, 4)};
        tbl[6]  = '{op(0,0, 0,0,0,            0,0,  1,'h55,full_mask),     ex(0,'hDEADBEEF,  1,4,1,3, 4)};
        tbl[7]  = '{op(0,0, 0,0,0,            0,0,  1,'h54,'hFE),          ex(0,'hDEADBEEF,  1,4,1,3, 4)};
        tbl[8]  = '{op(0,0, 1,2,'h1234,       0,0,  1,'h1234,full_mask),   ex(0,'hDEADBEEF,  0,0,0,0, 5)};
        tbl[9]  = '{op(0,0, 0,0,0,            0,0,  1,'h1234,full_mask),   ex(0,'hDEADBEEF,  1,2,0,1, 5)};
        tbl[10] = '{op(0,0, 0,0,0,            1,4,  0,0,0),                ex(0,'hDEADBEEF,  0,2,0,0, 4)};
        tbl[11] = '{op(0,0, 0,0,0,            0,0,  1,'h55,full_mask),     ex(0,'hDEADBEEF,  1,9,1,2, 4)};
        tbl[12] = '{op(0,0, 1,9,'h55,         1,9,  0,0,0),                ex(0,'hDEADBEEF,  0,9,0,0, 4)};
        tbl[13] = '{op(1,9, 0,0,0,            0,0,  1,'h55,full_mask),     ex(1,'h55,        1,9,1,2, 4)};
        tbl[14] = '{op(0,0, 0,0,0,            1,31, 0,0,0),                ex(0,'h55,        0,9,0,0, 4)};
        tbl[15] = '{op(0,0, 1,5,'hA,          1,20, 0,0,0),                ex(0,'h55,        0,9,0,0, 4)};
        tbl[16] = '{op(1,20,0,0,0,            0,0,  1,0,0),                ex(0,0,           1,2,1,4, 4)};
        tbl[17] = '{op(1,5, 0,0,0,            0,0,  0,0,0),                ex(1,'hA,         0,2,0,0, 4)};

        // Two reset cycles with no requests.
        for (int i = 0; i < 2; i++) begin
            s = op(0,0, 0,0,0, 0,0, 0,0,0);
            s.rst = 1'b0;
            apply($sformatf("reset%0d", i), s, ex(0,0, 0,0,0,0, 0));
        end

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
        end

        // Fill every index; entries 2,5,7,9 are already valid and do not add.
        cnt = 4;
        for (int i = 0; i < 32; i++) begin
            if (!(i inside {2, 5, 7, 9})) cnt++;
            apply($sformatf("fill%0d", i), op(0,0, 1,i,32'(i*3+1), 0,0, 0,0,0),
                  ex(0,'hA, 0,2,0,0, cnt));
        end

        // Overwrite index 0 while full; read and all-don't-care search see old state.
        apply("overwrite0", op(1,0, 1,0,'h99, 0,0, 1,0,0), ex(1,1, 1,0,1,32, 32));
        apply("reread0",    op(1,0, 0,0,0,    0,0, 0,0,0), ex(1,'h99, 0,0,0,0, 32));

        // Reset overrides a same-cycle write.
        s = op(0,0, 1,1,'h77, 0,0, 0,0,0);
        s.rst = 1'b0;
        apply("midreset", s, ex(0,0, 0,0,0,0, 0));
        apply("postreset", op(1,1, 0,0,0, 0,0, 1,0,0), ex(0,0, 0,0,0,0, 0));
        apply("rewrite3",  op(0,0, 1,3,'h33, 0,0, 0,0,0), ex(0,0, 0,0,0,0, 1));
        apply("reread3",   op(1,3, 0,0,0, 0,0, 1,'h33,full_mask), ex(1,'h33, 1,3,0,1, 1));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_param.md
Name: cam_param

Overview:
- Parametrised, registered-output content-addressable memory; next generation of the 32x32 CAM.
- Adds per-entry valid bits, explicit invalidate, masked search, multi-hit and match-count reporting, and occupancy flags.
- Sits beside the register/lookup logic. Read, write, invalidate and search may all be issued in the same cycle.

Parameters:
- DATA_WIDTH, 32, entry width in bits
- ADDR_WIDTH, 5, index width
- DEPTH, 1<<ADDR_WIDTH, number of entries; must be a power of two, >=2

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- read_i  in  1  read request
- read_index_i  in  ADDR_WIDTH  read index
- write_i  in  1  write request; sets the entry valid
- write_index_i  in  ADDR_WIDTH  write index
- write_data_i  in  DATA_WIDTH  write data
- inval_i  in  1  invalidate request
- inval_index_i  in  ADDR_WIDTH  index to invalidate
- search_i  in  1  search request
- search_data_i  in  DATA_WIDTH  search key
- search_mask_i  in  DATA_WIDTH  1 = compare bit, 0 = don't-care
- read_valid_o  out  1  read result valid
- read_value_o  out  DATA_WIDTH  read data
- search_valid_o  out  1  at least one hit
- search_index_o  out  ADDR_WIDTH  lowest hitting index
- search_multi_o  out  1  more than one hit
- search_count_o  out  ADDR_WIDTH+1  number of hits
- count_o  out  ADDR_WIDTH+1  number of valid entries
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0

Behaviour:
- Reset: with rst_i=0 at a clock edge, all valid bits are cleared and every output goes to 0, except empty_o, which goes to 1. The data array is not reset. Reset overrides all same-cycle requests.
- Latency: read and search results are registered and appear one cycle after the request. They are held until the next request of the same type.
- Read:
  - read_i in cycle N gives read_valid_o=valid[idx] in N+1.
  - read_value_o=data[idx] if the entry is valid, else 0.
  - If read_i=0 in cycle N, read_valid_o=0 in N+1 and read_value_o holds its last value.
- Search:
  - Entry i hits when valid[i] && ((data[i] ^ key) & mask) == 0.
  - search_index_o is the lowest hitting index, or 0 if none.
  - search_valid_o=|hit. search_multi_o is set when there are >=2 hits. search_count_o=popcount(hit).
  - If search_i=0, search_valid_o, search_multi_o and search_count_o are 0 in the next cycle; search_index_o holds.
  - A mask of all zeros matches every valid entry.
- Ordering within a cycle: read-before-write. Read and search see array state from before that cycle's write or invalidate.
- Write: data[idx] <= write_data_i and valid[idx] <= 1. Overwriting an already valid entry does not change count_o.
- Invalidate: valid[idx] <= 0. Invalidating an already invalid entry is a no-op.
- Write and invalidate to the same index in the same cycle: the write wins and the entry ends valid.
- Write and invalidate to different indices: both take effect.
- count_o update: net change of +1, 0 or -1, registered with the array; count_o, full_o and empty_o are consistent with the array every cycle.
  - Computed from the pre-update valid bits, so the counter never overflows past DEPTH or underflows below 0.
- No state machine beyond the storage and counter; no backpressure. Every request is accepted every cycle.

Decomposition:
- Package cam_pkg:
  - Default DATA_WIDTH/ADDR_WIDTH constants.
  - Typedefs cam_data_t, cam_idx_t, cam_cnt_t.
  - Function popcount.
- Sub-module cam_prio_enc (DEPTH one-hot-or-more vector -> lowest index, any, multi); parametrised on DEPTH.
- Top module holds the data array, valid vector, counter and output registers.

Test Plan:
- Reset:
  - Hold rst_i=0 for 2 cycles, then read index 3 -> read_valid_o=0, read_value_o=0.
  - count_o=0, empty_o=1, full_o=0.
- Write then read and search:
  - Write 0xDEADBEEF to index 7. Next cycle, read 7 and search 0xDEADBEEF with mask 0xFFFFFFFF.
  - One cycle later: read_value_o=0xDEADBEEF, search_valid_o=1, search_index_o=7, search_count_o=1, count_o=1.
- Priority and multi-hit:
  - Write 0x55 to indices 9, 4 and 20. Search 0x55 with full mask.
  - Required: search_index_o=4, search_multi_o=1, search_count_o=3.
  - Search 0x54 with mask 0xFE -> same three hits.
- Read-before-write:
  - In the same cycle, write 0x1234 to index 2 and search 0x1234 -> search_valid_o=0.
  - Repeat the search next cycle -> search_valid_o=1, search_index_o=2.
- Invalidate and collisions:
  - Invalidate index 4 -> the 0x55 search gives index 9, count 2.
  - Write and invalidate index 9 in the same cycle -> entry 9 stays valid and count_o is unchanged.
  - Invalidate an empty index -> count_o is unchanged.
- Full and mid-operation reset:
  - Write all 32 indices -> full_o=1, count_o=32. Overwrite index 0 -> count_o stays 32.
  - Assert rst_i=0 together with a write to index 1 -> count_o=0, empty_o=1, index 1 reads invalid.
